// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART command receiver: FSM state
// encoding, opcode values and active-low 7-segment patterns (abcdefg, g = LSB).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_BREAK  = 3'd6
  } state_e;

  localparam logic [3:0] OP_CLEAR = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_SHOW  = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h8;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Serial input and display/status outputs of the UART command receiver.
// master = board/bench side, slave = receiver side.
interface uart_rx_cmd_if #(
  parameter int DATA_BITS = 8
);
  logic                 dado;
  logic [DATA_BITS-1:0] leds;
  logic [6:0]           seg_dezena;
  logic [6:0]           seg_unidade;
  logic                 byte_valid;
  logic                 frame_err;
  logic [2:0]           estado;

  modport master (
    output dado,
    input  leds, seg_dezena, seg_unidade, byte_valid, frame_err, estado
  );

  modport slave (
    input  dado,
    output leds, seg_dezena, seg_unidade, byte_valid, frame_err, estado
  );
endinterface

// File: rtl/uart_rx_cmd_seg7_dec.sv
// Decimal digit to active-low 7-segment pattern; non-decimal inputs blank.
module seg7_dec
  import uart_rx_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// Oversampling UART receiver with 4-bit opcode decoder and two-digit display.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_cmd
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_cmd_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] leds_q, leds_d;
  logic [3:0]           value_q, value_d;
  logic [3:0]           disp_q, disp_d;
  logic [6:0]           seg_dez_q, seg_uni_q;
  logic [6:0]           seg_dez_d, seg_uni_d;
  logic                 byte_valid, frame_err;
  logic                 tens;
  logic [3:0]           units;
  logic [3:0]           opcode, operand;

  assign opcode  = shreg_q[DATA_BITS-1 -: 4];
  assign operand = shreg_q[3:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    leds_d     = leds_q;
    value_d    = value_q;
    disp_d     = disp_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (!sync2_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (sync2_q != ^shreg_q) begin
            perr_d    = 1'b1;
            frame_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        // A parity failure has already pulsed frame_err; only the line state matters now.
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = perr_q ? ST_IDLE : ST_EXEC;
          end else begin
            frame_err = !perr_q;
            state_d   = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        byte_valid = 1'b1;
        leds_d     = shreg_q;
        state_d    = ST_IDLE;
        case (opcode)
          OP_CLEAR: begin
            value_d = '0;
            disp_d  = '0;
          end
          OP_LOAD: value_d = operand;
          OP_SHOW: disp_d  = value_q;
          OP_ADD:  value_d = value_q + operand;
          default: ;
        endcase
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Segments are decoded from the next display value so they register with it.
  assign tens  = (disp_d >= 4'd10);
  assign units = tens ? (disp_d - 4'd10) : disp_d;

  seg7_dec u_tens (
    .digit_i ({3'b000, tens}),
    .seg_o   (seg_dez_d)
  );

  seg7_dec u_units (
    .digit_i (units),
    .seg_o   (seg_uni_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      leds_q    <= '0;
      value_q   <= '0;
      disp_q    <= '0;
      seg_dez_q <= SEG_0;
      seg_uni_q <= SEG_0;
    end else begin
      sync1_q   <= bus.dado;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      leds_q    <= leds_d;
      value_q   <= value_d;
      disp_q    <= disp_d;
      seg_dez_q <= seg_dez_d;
      seg_uni_q <= seg_uni_d;
    end
  end

  assign bus.leds        = leds_q;
  assign bus.seg_dezena  = seg_dez_q;
  assign bus.seg_unidade = seg_uni_q;
  assign bus.byte_valid  = byte_valid;
  assign bus.frame_err   = frame_err;
  assign bus.estado      = state_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd: serial frames in, scoreboard of expected
// leds/segments checked the cycle after each byte_valid.
module tb_uart_rx_cmd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   bv_cnt = 0;
  int   fe_cnt = 0;
  int   exp_bv = 0;
  int   exp_fe = 0;
  logic [3:0] m_value = 4'd0;
  logic [3:0] m_disp  = 4'd0;

  typedef struct packed {
    logic [7:0] leds;
    logic [6:0] dez;
    logic [6:0] uni;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_cmd_if #(.DATA_BITS(8)) io ();

  uart_rx_cmd #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] tb_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference behaviour of one accepted frame; pushes what the display must show.
  task automatic model_frame(input logic [7:0] b);
    exp_t e;
    case (b[7:4])
      4'h1: begin m_value = 4'd0; m_disp = 4'd0; end
      4'h2: m_value = b[3:0];
      4'h4: m_disp = m_value;
      4'h8: m_value = m_value + b[3:0];
      default: ;
    endcase
    e.leds = b;
    e.dez  = (m_disp >= 4'd10) ? tb_seg(4'd1) : tb_seg(4'd0);
    e.uni  = tb_seg(m_disp % 10);
    exp_q.push_back(e);
    exp_bv++;
  endtask

  task automatic align();
    @(negedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns,
                            input logic bad_par);
    io.dado = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      io.dado = b[i];
      #(bit_ns);
    end
`ifdef UART_RX_PARITY_EN
    io.dado = (^b) ^ bad_par;
    #(bit_ns);
`else
    if (bad_par) $display("note: parity not built in");
`endif
    io.dado = stop_bit;
    #(bit_ns);
  endtask

  task automatic good(input logic [7:0] b);
    model_frame(b);
    send_frame(b, 1'b1, 160, 1'b0);
    #320;
  endtask

  // Monitor: byte_valid is seen mid-EXEC; registered results are checked one cycle later.
  logic pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("sb_nonempty", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_leds", io.leds, e.leds);
        chk("sb_dezena", io.seg_dezena, e.dez);
        chk("sb_unidade", io.seg_unidade, e.uni);
      end
    end
    pend = io.byte_valid;
    if (io.byte_valid) bv_cnt++;
    if (io.frame_err) fe_cnt++;
    if (io.byte_valid || io.frame_err) chk("bv_fe_excl", io.byte_valid & io.frame_err, 0);
  end

  initial begin
    io.dado = 1'b1;
    rst = 1'b0;
    #35;
    chk("rst_estado", io.estado, 0);
    chk("rst_leds", io.leds, 8'h00);
    chk("rst_dezena", io.seg_dezena, 7'b0000001);
    chk("rst_unidade", io.seg_unidade, 7'b0000001);
    chk("rst_bv", io.byte_valid, 0);
    chk("rst_fe", io.frame_err, 0);
    rst = 1'b1;
    #100;

    // Reset in the middle of a frame
    align();
    io.dado = 1'b0;
    #(160 * 4);
    chk("mid_data_estado", io.estado, 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_estado", io.estado, 0);
    io.dado = 1'b1;
    #20;
    rst = 1'b1;
    #300;

    align();
    good(8'h2A);
    good(8'h40);
    chk("ten_leds", io.leds, 8'h40);
    chk("ten_dezena", io.seg_dezena, 7'b1001111);
    chk("ten_unidade", io.seg_unidade, 7'b0000001);

    good(8'h27);
    good(8'h84);
    good(8'h40);
    chk("eleven_dezena", io.seg_dezena, 7'b1001111);
    chk("eleven_unidade", io.seg_unidade, 7'b1001111);

    good(8'h2F);
    good(8'h82);
    good(8'h40);
    chk("wrap_dezena", io.seg_dezena, 7'b0000001);
    chk("wrap_unidade", io.seg_unidade, 7'b1001111);

    // Start glitch of 5 cycles
    align();
    io.dado = 1'b0;
    #50;
    io.dado = 1'b1;
    #400;
    chk("glitch_estado", io.estado, 0);
    chk("glitch_bv", bv_cnt, exp_bv);
    chk("glitch_fe", fe_cnt, exp_fe);

    // Stop bit low, line held low 40 cycles from the stop bit
    align();
    send_frame(8'h45, 1'b0, 160, 1'b0);
    exp_fe++;
    #10;
    chk("break_estado", io.estado, 6);
    #230;
    chk("break_hold_estado", io.estado, 6);
    io.dado = 1'b1;
    #60;
    chk("break_exit_estado", io.estado, 0);
    chk("break_fe_cnt", fe_cnt, exp_fe);
    chk("break_leds", io.leds, 8'h40);
    chk("break_unidade", io.seg_unidade, 7'b1001111);
    #200;

    // Back-to-back frames, sender 3% fast
    align();
    model_frame(8'h13);
    send_frame(8'h13, 1'b1, 155, 1'b0);
    model_frame(8'h40);
    send_frame(8'h40, 1'b1, 155, 1'b0);
    #200;
    chk("b2b_bv", bv_cnt, exp_bv);
    chk("b2b_dezena", io.seg_dezena, 7'b0000001);
    chk("b2b_unidade", io.seg_unidade, 7'b0000001);

`ifdef UART_RX_PARITY_EN
    align();
    send_frame(8'h2A, 1'b1, 160, 1'b1);
    exp_fe++;
    #320;
    chk("par_bad_fe", fe_cnt, exp_fe);
    good(8'h40);
    chk("par_bad_unidade", io.seg_unidade, 7'b0000001);
    good(8'h2A);
    good(8'h40);
    chk("par_good_dezena", io.seg_dezena, 7'b1001111);
`endif

    #200;
    chk("final_bv", bv_cnt, exp_bv);
    chk("final_fe", fe_cnt, exp_fe);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_cmd.md
# uart_rx_cmd

Parametrised UART receiver with command decoder and two-digit 7-segment display driver; replaces the fixed-rate serial command receiver on the board. It oversamples the serial line, validates start/stop framing, and executes the 4-bit opcode carried in the upper nibble of each frame. Output mirrors the last received byte on LEDs and shows a 4-bit stored value as decimal 00–15.

## Interface
Parameters:
- OVERSAMPLE, 16: clk cycles per bit; even, ≥4.
- DATA_BITS, 8: data bits per frame, LSB first; ≥5. Opcode = top 4 bits, operand = bottom 4 bits.

Ports:
- clk  in  1  oversample clock (bit rate × OVERSAMPLE).
- rst  in  1  asynchronous, active-low reset.
- dado  in  1  serial line, idle high; asynchronous to clk.
- leds  out  DATA_BITS  last correctly framed byte.
- seg_dezena  out  7  tens digit, active-low, bit order abcdefg (g = LSB).
- seg_unidade  out  7  units digit, same encoding.
- byte_valid  out  1  one-cycle pulse in the EXEC cycle of each accepted frame.
- frame_err  out  1  one-cycle pulse when the stop bit (or parity) fails.
- estado  out  3  current FSM state, for debug.

## Operation
- dado passes through a 2-FF synchroniser; all logic uses the synchronised copy.
- States: IDLE(0), START(1), DATA(2), PARITY(3), STOP(4), EXEC(5), BREAK(6).
- IDLE: on synced line = 0 → START, clear tick counter.
- START: after OVERSAMPLE/2−1 further cycles, resample: 0 → DATA; 1 → IDLE (glitch, no error).
- DATA: sample every OVERSAMPLE cycles, shift into bit index 0..DATA_BITS−1; after last bit → PARITY if enabled, else STOP.
- STOP: sample after OVERSAMPLE cycles: 1 → EXEC; 0 → pulse frame_err, go to BREAK.
- BREAK: wait until line = 1, then IDLE. Frame discarded; leds/value untouched.
- EXEC (one cycle): leds ← byte, byte_valid = 1, then decode opcode:
  - 4'h1 CLEAR: value ← 0, display "00".
  - 4'h2 LOAD: value ← operand; display unchanged.
  - 4'h4 SHOW: display value.
  - 4'h8 ADD: value ← (value + operand) mod 16; display unchanged.
  - other: no action beyond leds.
  - then → IDLE.
- Display: seg_dezena = "1" (7'b1001111) if value ≥ 10 else "0" (7'b0000001); seg_unidade = digit (value mod 10).
- Reset (any state, incl. mid-frame): estado = IDLE, value = 0, leds = 0, both segments 7'b0000001, byte_valid = 0, frame_err = 0, counters 0.

## Timing
- Input synchroniser adds 2 cycles before start edge seen.
- Samples taken at bit centre ±1 cycle; tolerates ±(OVERSAMPLE/2−2)/(10·OVERSAMPLE) baud mismatch.
- EXEC is the cycle after the stop-bit sample; leds, value and segments registered, visible the cycle after EXEC.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with a single stop bit.
- byte_valid and frame_err never assert in the same cycle.

## Configuration
- UART_RX_PARITY_EN defined: one even-parity bit follows data; PARITY state samples it; mismatch → frame_err pulse, frame discarded (still checks stop, then IDLE/BREAK as above, no second pulse).
- Undefined: no parity bit; PARITY state unreachable; frame = start + DATA_BITS + stop.

## Structure
- Package uart_rx_pkg: state enum, opcode constants (OP_CLEAR, OP_LOAD, OP_SHOW, OP_ADD), 7-segment constants for 0–9.
- Sub-module seg7_dec: 4-bit digit → 7-bit active-low pattern, instantiated twice (tens, units).

## Test plan
- Reset mid-DATA, release, send 0x2A then 0x40 → after second EXEC: leds = 8'h40, seg_dezena = 7'b1001111, seg_unidade = 7'b0000001 ("10").
- Send 0x27, 0x84, 0x40 → value 11, display "11" (dezena 7'b1001111, unidade 7'b1001111); ADD wraps: 0x2F, 0x82, 0x40 → "01".
- Line low for 5 cycles only (OVERSAMPLE=16) → returns to IDLE, no byte_valid, no frame_err.
- Frame 0x45 with stop bit 0, line low 40 cycles → one frame_err pulse, leds unchanged, estado = BREAK until line high.
- Back-to-back 0x13, 0x40 with one stop bit, sender baud +3% → both accepted, display "00".
- With UART_RX_PARITY_EN: 0x2A with wrong parity → frame_err, value unchanged; correct parity → byte_valid.
